// File: rtl/vga_pkg.sv
// Shared VGA types: resolution encoding and the mode-change sequencer states.
package vga_pkg;

    localparam int VGA_RES_W = 3;

    typedef enum logic [VGA_RES_W-1:0] {
        VGA_RES_640_480   = 3'd0,
        VGA_RES_800_600   = 3'd1,
        VGA_RES_1024_768  = 3'd2,
        VGA_RES_1280_1024 = 3'd3
    } vga_resolution_e;

    // Number of supported resolutions; encodings at or above this are invalid.
    localparam logic [VGA_RES_W-1:0] VGA_RES_NUM = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        LOAD,
        WAIT_MEM,
        CLK_CFG,
        WAIT_LOCK,
        DONE
    } vga_mode_ctrl_state_e;

    function automatic logic vga_res_valid(input logic [VGA_RES_W-1:0] res);
        return res < VGA_RES_NUM;
    endfunction

endpackage

// File: rtl/vga_lock_filter.sv
// Clock-generator lock qualifier: lock is only trusted after it has been seen
// to drop (the generator actually restarted) and then stayed high for
// LOCK_STABLE consecutive cycles.
module vga_lock_filter #(
    parameter int LOCK_STABLE = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic lock_i,
    output logic stable_o
);

    localparam int CNT_W = $clog2(LOCK_STABLE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_STABLE);

    logic             unlock_seen;
    logic [CNT_W-1:0] cnt;

    // Track the unlock event and count consecutive high-lock cycles after it, saturating.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            unlock_seen <= 1'b0;
            cnt         <= '0;
        end else if (!lock_i) begin
            unlock_seen <= 1'b1;
            cnt         <= '0;
        end else if (unlock_seen && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign stable_o = (cnt == CNT_MAX);

endmodule

// File: rtl/vga_mode_ctrl.sv
// Resolution-change sequencer: drains the timing generator at a frame
// boundary, fetches the new timing set, reconfigures the pixel clock and
// re-enables the timing generator once the clock is stably locked.
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mode_req_i,
    input  vga_resolution_e mode_i,
    output logic            mode_ack_o,
    output logic            err_o,
    output logic            busy_o,
    output vga_resolution_e cur_mode_o,
    output logic            mem_req_o,
    output vga_resolution_e mem_res_o,
    input  logic            mem_valid_i,
    output logic            clkgen_cfg_o,
    input  logic            clkgen_lock_i,
    output logic            tg_en_o,
    input  logic            tg_frame_end_i
);

    localparam int TMR_MAX = (LOCK_TIMEOUT > MEM_TIMEOUT) ? LOCK_TIMEOUT : MEM_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] MEM_LAST  = TMR_W'(MEM_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);

    vga_mode_ctrl_state_e state;
    vga_resolution_e      tgt_mode;
    logic [TMR_W-1:0]     tmr;
    logic                 valid_prev;
    logic                 lock_stable;

    vga_lock_filter #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_filter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (state == CLK_CFG),
        .lock_i  (clkgen_lock_i),
        .stable_o(lock_stable)
    );

    // Sequencer FSM; every output is a register updated on the transition into the state that owns it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            tgt_mode     <= VGA_RES_800_600;
            tmr          <= '0;
            valid_prev   <= 1'b0;
            mode_ack_o   <= 1'b0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
            cur_mode_o   <= VGA_RES_800_600;
            mem_req_o    <= 1'b0;
            mem_res_o    <= VGA_RES_800_600;
            clkgen_cfg_o <= 1'b0;
            tg_en_o      <= 1'b0;
        end else begin
            mode_ack_o   <= 1'b0;
            err_o        <= 1'b0;
            mem_req_o    <= 1'b0;
            clkgen_cfg_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mode_req_i) begin
                        if (!vga_res_valid(mode_i)) begin
                            err_o <= 1'b1;
                        end else if ((mode_i == cur_mode_o) && tg_en_o) begin
                            mode_ack_o <= 1'b1;
                        end else begin
                            tgt_mode <= mode_i;
                            busy_o   <= 1'b1;
                            if (tg_en_o) begin
                                state <= DRAIN;
                            end else begin
                                state     <= LOAD;
                                mem_req_o <= 1'b1;
                                mem_res_o <= mode_i;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // A frame end coinciding with acceptance was seen in IDLE and is not counted here.
                    if (tg_frame_end_i) begin
                        tg_en_o   <= 1'b0;
                        state     <= LOAD;
                        mem_req_o <= 1'b1;
                        mem_res_o <= tgt_mode;
                    end
                end
                LOAD: begin
                    tmr   <= '0;
                    state <= WAIT_MEM;
                end
                WAIT_MEM: begin
                    if (mem_valid_i != valid_prev) begin
                        valid_prev   <= mem_valid_i;
                        clkgen_cfg_o <= 1'b1;
                        state        <= CLK_CFG;
                    end else if (tmr == MEM_LAST) begin
                        err_o   <= 1'b1;
                        busy_o  <= 1'b0;
                        tg_en_o <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                CLK_CFG: begin
                    tmr   <= '0;
                    state <= WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_stable) begin
                        state <= DONE;
                    end else if (tmr == LOCK_LAST) begin
                        err_o   <= 1'b1;
                        busy_o  <= 1'b0;
                        tg_en_o <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                DONE: begin
                    tg_en_o    <= 1'b1;
                    cur_mode_o <= tgt_mode;
                    mode_ack_o <= 1'b1;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for the VGA mode-change sequencer.
module tb_vga_mode_ctrl;
    import vga_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            mode_req;
    vga_resolution_e mode;
    logic            mode_ack, err, busy, mem_req, clkgen_cfg, tg_en;
    vga_resolution_e cur_mode, mem_res;
    logic            mem_valid, lock, frame_end;

    int n_cmp = 0;
    int n_bad = 0;

    vga_mode_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mode_req_i    (mode_req),
        .mode_i        (mode),
        .mode_ack_o    (mode_ack),
        .err_o         (err),
        .busy_o        (busy),
        .cur_mode_o    (cur_mode),
        .mem_req_o     (mem_req),
        .mem_res_o     (mem_res),
        .mem_valid_i   (mem_valid),
        .clkgen_cfg_o  (clkgen_cfg),
        .clkgen_lock_i (lock),
        .tg_en_o       (tg_en),
        .tg_frame_end_i(frame_end)
    );

    always #5 clk = ~clk;

    // One request scenario. Times are cycles after the request cycle (0); -1 = never.
    typedef struct {
        vga_resolution_e mode;
        int              mem_dly;   // cycles from mem_req to valid toggle, -1 never
        int              lk_drop;   // cycles from cfg to lock low, -1 never drops
        int              lk_low;    // low duration
        int              glitch;    // single low cycle this many highs after recovery, -1 none
        int              fe;        // frame end cycle, -1 none (also pulsed at cycle 0 if >= 0)
        int              budget;
        int              e_memreq;
        int              e_cfg;
        int              e_ack;
        int              e_err;
        int              e_tgfall;
        int              e_tg_en;
        vga_resolution_e e_cur;
    } vec_t;

    vec_t vecs[7];
    vec_t post_rst;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tg_en"},    int'(tg_en), 0);
        chk({tag, "_busy"},     int'(busy), 0);
        chk({tag, "_ack"},      int'(mode_ack), 0);
        chk({tag, "_err"},      int'(err), 0);
        chk({tag, "_mem_req"},  int'(mem_req), 0);
        chk({tag, "_cfg"},      int'(clkgen_cfg), 0);
        chk({tag, "_cur_mode"}, int'(cur_mode), int'(VGA_RES_800_600));
        chk({tag, "_mem_res"},  int'(mem_res), int'(VGA_RES_800_600));
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        int t = 0;
        int t_memreq = -1, t_cfg = -1, t_ack = -1, t_err = -1, t_fall = -1;
        int n_memreq = 0, n_cfg = 0, n_ack = 0, busy1 = -1, busy_end = -1;
        int res_at_req = -1, tg_end = -1, cur_end = -1, rel;
        logic done = 1'b0;
        mode_req  = 1'b1;
        mode      = v.mode;
        frame_end = (v.fe >= 0);
        while (!done && t < v.budget) begin
            step();
            t++;
            if (mem_req) begin
                n_memreq++;
                if (t_memreq < 0) begin
                    t_memreq   = t;
                    res_at_req = int'(mem_res);
                end
            end
            if (clkgen_cfg) begin
                n_cfg++;
                if (t_cfg < 0) t_cfg = t;
            end
            if (t == 1) busy1 = int'(busy);
            if (!tg_en && t_fall < 0) t_fall = t;
            if (mode_ack) begin
                n_ack++;
                if (t_ack < 0) t_ack = t;
            end
            if (err && t_err < 0) t_err = t;
            if (mode_ack || err) begin
                done     = 1'b1;
                busy_end = int'(busy);
                tg_end   = int'(tg_en);
                cur_end  = int'(cur_mode);
            end
            // Inputs for cycle t: an invalid request while busy must be ignored.
            mode_req  = !done && (t <= 3);
            mode      = vga_resolution_e'(3'd7);
            frame_end = (t == v.fe);
            if (v.mem_dly >= 0 && t_memreq >= 0 && t == t_memreq + v.mem_dly)
                mem_valid = ~mem_valid;
            if (t_cfg >= 0 && v.lk_drop >= 0) begin
                rel  = t - t_cfg;
                lock = !((rel >= v.lk_drop && rel < v.lk_drop + v.lk_low) ||
                         (v.glitch >= 0 && rel == v.lk_drop + v.lk_low + v.glitch));
            end else begin
                lock = 1'b1;
            end
        end
        mode_req  = 1'b0;
        frame_end = 1'b0;
        lock      = 1'b1;
        if (!done) chk($sformatf("v%0d_completion_timeout", idx), 0, 1);
        chk($sformatf("v%0d_memreq_cycle", idx), t_memreq, v.e_memreq);
        chk($sformatf("v%0d_memreq_count", idx), n_memreq, (v.e_memreq >= 0) ? 1 : 0);
        if (v.e_memreq >= 0) chk($sformatf("v%0d_mem_res", idx), res_at_req, int'(v.mode));
        chk($sformatf("v%0d_cfg_cycle", idx), t_cfg, v.e_cfg);
        chk($sformatf("v%0d_cfg_count", idx), n_cfg, (v.e_cfg >= 0) ? 1 : 0);
        chk($sformatf("v%0d_ack_cycle", idx), t_ack, v.e_ack);
        chk($sformatf("v%0d_ack_count", idx), n_ack, (v.e_ack >= 0) ? 1 : 0);
        chk($sformatf("v%0d_err_cycle", idx), t_err, v.e_err);
        chk($sformatf("v%0d_tg_fall", idx), t_fall, v.e_tgfall);
        chk($sformatf("v%0d_busy_n1", idx), busy1, (v.e_memreq >= 0) ? 1 : 0);
        chk($sformatf("v%0d_busy_end", idx), busy_end, 0);
        chk($sformatf("v%0d_tg_en_end", idx), tg_end, v.e_tg_en);
        chk($sformatf("v%0d_cur_mode", idx), cur_end, int'(v.e_cur));
    endtask

    initial begin
        //         mode               mem drop low glt  fe  budget  mreq cfg  ack    err    fall tg cur
        vecs[0] = '{VGA_RES_1280_1024,  1,  2,  3, -1, -1,   200,    1,   3,  26,    -1,     1, 1, VGA_RES_1280_1024};
        vecs[1] = '{VGA_RES_800_600,    1,  2,  3, -1, 50,   200,   51,  53,  76,    -1,    51, 1, VGA_RES_800_600};
        vecs[2] = '{VGA_RES_800_600,    1,  2,  3, -1, -1,    20,   -1,  -1,   1,    -1,    -1, 1, VGA_RES_800_600};
        vecs[3] = '{vga_resolution_e'(3'd5), 1, 2, 3, -1, -1, 20,   -1,  -1,  -1,     1,    -1, 1, VGA_RES_800_600};
        vecs[4] = '{VGA_RES_1280_1024,  1,  2,  3, 10,  3,   200,    4,   6,  40,    -1,     4, 1, VGA_RES_1280_1024};
        vecs[5] = '{VGA_RES_640_480,   -1,  2,  3, -1,  2,   200,    3,  -1,  -1,    19,     3, 0, VGA_RES_1280_1024};
        vecs[6] = '{VGA_RES_1024_768,   1, -1,  0, -1, -1, 70000,    1,   3,  -1, 65539,     1, 0, VGA_RES_1280_1024};
        post_rst = '{VGA_RES_800_600,   1,  1,  1, -1, -1,   200,    1,   3,  23,    -1,     1, 1, VGA_RES_800_600};

        rst       = 1'b1;
        mode_req  = 1'b0;
        mode      = VGA_RES_640_480;
        mem_valid = 1'b0;
        lock      = 1'b1;
        frame_end = 1'b0;
        step();
        check_reset("por");
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            apply_vec(i, vecs[i]);
            step();
        end

        // Reset while waiting for lock: everything back to reset values one cycle later.
        mode_req = 1'b1;
        mode     = VGA_RES_640_480;
        step();
        mode_req = 1'b0;
        step();
        mem_valid = ~mem_valid;
        repeat (5) step();
        chk("mid_busy_before_rst", int'(busy), 1);
        chk("mid_mem_res_before_rst", int'(mem_res), int'(VGA_RES_640_480));
        rst = 1'b1;
        step();
        check_reset("mid");
        rst       = 1'b0;
        mem_valid = 1'b0;
        step();

        apply_vec(7, post_rst);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
